// File: rtl/alu_param_seq_pkg.sv
// Shared definitions for the handshaked ALU: opcode values, FSM states and the flag layout.
`timescale 1ns/1ps
package alu_param_seq_pkg;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_MUL = 2;
  localparam int unsigned OP_DIV = 3;
  localparam int unsigned OP_MOD = 4;
  localparam int unsigned OP_AND = 5;
  localparam int unsigned OP_OR  = 6;
  localparam int unsigned OP_XOR = 7;
  localparam int unsigned OP_NOT = 8;
  localparam int unsigned OP_SHL = 9;
  localparam int unsigned OP_SHR = 10;
  localparam int unsigned OP_ROL = 11;
  localparam int unsigned OP_ROR = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DIV_RUN,
    S_RESP
  } state_e;

  // Field order gives the external bit layout {ILLEGAL, DIV0, OVF, CARRY, ZERO}.
  typedef struct packed {
    logic illegal;
    logic div0;
    logic ovf;
    logic carry;
    logic zero;
  } flags_t;

endpackage

// File: rtl/alu_param_seq_div.sv
// Restoring divider, one quotient bit per clock; DONE_O pulses exactly W cycles after START_I.
`timescale 1ns/1ps
module alu_div_seq #(
  parameter int unsigned W = 8
) (
  input  logic         CLK_I,
  input  logic         RST_I,
  input  logic         START_I,
  input  logic [W-1:0] DIVIDEND_I,
  input  logic [W-1:0] DIVISOR_I,
  output logic         DONE_O,
  output logic [W-1:0] QUOT_O,
  output logic [W-1:0] REM_O
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, quot_q, dsor_q;
  logic [CW-1:0] cnt_q;
  logic          run_q, done_q;

  logic [W-1:0] rem_in, quot_in, dsor_in, rem_nx, quot_nx;
  logic [W:0]   trial;
  logic         qbit;

  // The first iteration happens on the START edge itself, straight from the inputs.
  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    rem_in  = START_I ? '0 : rem_q;
    quot_in = START_I ? DIVIDEND_I : quot_q;
    dsor_in = START_I ? DIVISOR_I : dsor_q;
    trial   = {rem_in, quot_in[W-1]};
    qbit    = (trial >= {1'b0, dsor_in});
    rem_nx  = qbit ? W'(trial - {1'b0, dsor_in}) : trial[W-1:0];
    quot_nx = {quot_in[W-2:0], qbit};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      rem_q  <= '0;
      quot_q <= '0;
      dsor_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (START_I) begin
        rem_q  <= rem_nx;
        quot_q <= quot_nx;
        dsor_q <= DIVISOR_I;
        cnt_q  <= CW'(W - 1);
        run_q  <= 1'b1;
      end else if (run_q) begin
        rem_q  <= rem_nx;
        quot_q <= quot_nx;
        cnt_q  <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign DONE_O = done_q;
  assign QUOT_O = quot_q;
  assign REM_O  = rem_q;

endmodule

// File: rtl/alu_param_seq.sv
// Handshaked parametrised ALU: one command in flight, single-cycle datapath plus iterative DIV/MOD.
`timescale 1ns/1ps
module alu_param_seq
  import alu_param_seq_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned OPC_W = 4
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             IN_VALID_I,
  output logic             IN_READY_O,
  input  logic [OPC_W-1:0] OPCODE_I,
  input  logic [W-1:0]     DATA_A_I,
  input  logic [W-1:0]     DATA_B_I,
  output logic             OUT_VALID_O,
  input  logic             OUT_READY_I,
  output logic [2*W-1:0]   DATA_OUT_O,
  output logic [4:0]       FLAGS_O,
  output logic             BUSY_O
);

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, b_q;
  logic [OPC_W-1:0]   op_q;
  logic [2*W-1:0]     data_q, res;
  flags_t             flags_q, flg;
  logic               out_valid_q;
  logic               is_div, div_start, div_done;
  logic [W-1:0]       div_quot, div_rem, rot_amt, diff;
  logic [W:0]         sum;
  logic [2*W-1:0]     rot_l, rot_r;

  assign is_div = (op_q == OPC_W'(OP_DIV)) || (op_q == OPC_W'(OP_MOD));

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    case (state_q)
      S_IDLE:    if (IN_VALID_I) state_d = S_EXEC;
      S_EXEC: begin
        if (is_div && (b_q != '0)) begin
          state_d   = S_DIV_RUN;
          div_start = 1'b1;
        end else begin
          state_d = S_RESP;
        end
      end
      S_DIV_RUN: if (div_done) state_d = S_RESP;
      S_RESP:    if (out_valid_q && OUT_READY_I) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res     = '0;
    flg     = '0;
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = a_q - b_q;
    rot_amt = W'(32'(b_q) % W);
    rot_l   = {a_q, a_q} << rot_amt;
    rot_r   = {a_q, a_q} >> rot_amt;
    case (op_q)
      OPC_W'(OP_ADD): begin
        res       = {{(W-1){1'b0}}, sum};
        flg.carry = sum[W];
        flg.ovf   = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
      end
      OPC_W'(OP_SUB): begin
        res       = {{W{1'b0}}, diff};
        flg.carry = (a_q < b_q);
        flg.ovf   = (a_q[W-1] != b_q[W-1]) && (diff[W-1] != a_q[W-1]);
      end
      OPC_W'(OP_MUL): res = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
      // Divide by zero never starts the divider: quotient all ones, remainder = A.
      OPC_W'(OP_DIV): begin
        flg.div0 = (b_q == '0);
        res      = flg.div0 ? {a_q, {W{1'b1}}} : {div_rem, div_quot};
      end
      OPC_W'(OP_MOD): begin
        flg.div0 = (b_q == '0);
        res      = {{W{1'b0}}, (flg.div0 ? a_q : div_rem)};
      end
      OPC_W'(OP_AND): res = {{W{1'b0}}, a_q & b_q};
      OPC_W'(OP_OR):  res = {{W{1'b0}}, a_q | b_q};
      OPC_W'(OP_XOR): res = {{W{1'b0}}, a_q ^ b_q};
      OPC_W'(OP_NOT): res = {{W{1'b0}}, ~a_q};
      OPC_W'(OP_SHL): res = (32'(b_q) >= W) ? '0 : {{W{1'b0}}, a_q << b_q};
      OPC_W'(OP_SHR): res = (32'(b_q) >= W) ? '0 : {{W{1'b0}}, a_q >> b_q};
      OPC_W'(OP_ROL): res = {{W{1'b0}}, rot_l[2*W-1:W]};
      OPC_W'(OP_ROR): res = {{W{1'b0}}, rot_r[W-1:0]};
      default:        flg.illegal = 1'b1;
    endcase
    flg.zero = (res == '0);
  end

  // NOTE: every register, including operands and results, is reset so an aborted command leaves no trace.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      data_q      <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && IN_VALID_I) begin
        a_q  <= DATA_A_I;
        b_q  <= DATA_B_I;
        op_q <= OPCODE_I;
      end
      if (state_d == S_RESP && state_q != S_RESP) begin
        data_q  <= res;
        flags_q <= flg;
      end
      // Valid follows RESP entry by one cycle and drops on the handshake edge.
      out_valid_q <= (state_q == S_RESP) && !(out_valid_q && OUT_READY_I);
    end
  end

  alu_div_seq #(.W(W)) u_div (
    .CLK_I      (CLK_I),
    .RST_I      (RST_I),
    .START_I    (div_start),
    .DIVIDEND_I (a_q),
    .DIVISOR_I  (b_q),
    .DONE_O     (div_done),
    .QUOT_O     (div_quot),
    .REM_O      (div_rem)
  );

  assign IN_READY_O  = (state_q == S_IDLE);
  assign BUSY_O      = (state_q != S_IDLE);
  assign OUT_VALID_O = out_valid_q;
  assign DATA_OUT_O  = data_q;
  assign FLAGS_O     = flags_q;

endmodule

// File: tb/tb_alu_param_seq.sv
// Directed bench for alu_param_seq (W=8): latency, data, flags, hold, back-pressure and abort-by-reset.
`timescale 1ns/1ps
module tb_alu_param_seq;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    opcode = '0;
  logic [W-1:0]  data_a = '0;
  logic [W-1:0]  data_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*W-1:0] data_out;
  logic [4:0]    flags;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  alu_param_seq #(.W(W), .OPC_W(4)) dut (
    .CLK_I       (clk),
    .RST_I       (rst),
    .IN_VALID_I  (in_valid),
    .IN_READY_O  (in_ready),
    .OPCODE_I    (opcode),
    .DATA_A_I    (data_a),
    .DATA_B_I    (data_b),
    .OUT_VALID_O (out_valid),
    .OUT_READY_I (out_ready),
    .DATA_OUT_O  (data_out),
    .FLAGS_O     (flags),
    .BUSY_O      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents a command at a negedge; returns #1 after acceptance edge N with operands scrambled.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = op;
    data_a   = a;
    data_b   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    opcode   = 4'(op + 4'd5);
    data_a   = W'($urandom);
    data_b   = W'($urandom);
  endtask

  // Counts edges after N until OUT_VALID is seen; 99 marks a timeout.
  task automatic wait_valid(output int n);
    n = 99;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd1);
    check("reset_busy",  32'(busy), 32'd0);
    check("reset_data",  32'(data_out), 32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    rst = 1'b0;

    issue(4'd0, 8'd200, 8'd100);
    check("add_busy", 32'(busy), 32'd1);
    wait_valid(lat);
    check("add_lat", 32'(lat), 32'd2);
    check("add_data", 32'(data_out), 32'h012C);
    check("add_flags", 32'(flags), 32'b00010);
    accept();
    check("add_valid_drop", 32'(out_valid), 32'd0);
    check("add_ready_back", 32'(in_ready), 32'd1);

    issue(4'd3, 8'd200, 8'd7);
    wait_valid(lat);
    check("div_lat", 32'(lat), 32'd10);
    check("div_data", 32'(data_out), 32'h041C);
    check("div_flags", 32'(flags), 32'b00000);
    accept();

    issue(4'd4, 8'd200, 8'd7);
    wait_valid(lat);
    check("mod_lat", 32'(lat), 32'd10);
    check("mod_data", 32'(data_out), 32'h0004);
    accept();

    issue(4'd3, 8'h55, 8'h00);
    wait_valid(lat);
    check("div0_lat", 32'(lat), 32'd2);
    check("div0_data", 32'(data_out), 32'h55FF);
    check("div0_flags", 32'(flags), 32'b01000);
    accept();

    issue(4'd1, 8'd3, 8'd5);
    wait_valid(lat);
    check("sub_data", 32'(data_out), 32'h00FE);
    check("sub_flags", 32'(flags), 32'b00010);
    accept();

    issue(4'd0, 8'h7F, 8'h01);
    wait_valid(lat);
    check("add_ovf_data", 32'(data_out), 32'h0080);
    check("add_ovf_flags", 32'(flags), 32'b00100);
    accept();

    issue(4'd11, 8'h81, 8'd9);
    wait_valid(lat);
    check("rol_data", 32'(data_out), 32'h0003);
    accept();

    issue(4'd12, 8'h81, 8'd0);
    wait_valid(lat);
    check("ror_data", 32'(data_out), 32'h0081);
    accept();

    issue(4'd9, 8'h01, 8'd8);
    wait_valid(lat);
    check("shl_data", 32'(data_out), 32'h0000);
    check("shl_flags", 32'(flags), 32'b00001);
    accept();

    issue(4'd10, 8'hF0, 8'd3);
    wait_valid(lat);
    check("shr_data", 32'(data_out), 32'h001E);
    accept();

    issue(4'd7, 8'hA5, 8'h0F);
    wait_valid(lat);
    check("xor_data", 32'(data_out), 32'h00AA);
    accept();

    issue(4'd8, 8'h0F, 8'h00);
    wait_valid(lat);
    check("not_data", 32'(data_out), 32'h00F0);
    accept();

    issue(4'd13, 8'h12, 8'h34);
    wait_valid(lat);
    check("illegal_lat", 32'(lat), 32'd2);
    check("illegal_data", 32'(data_out), 32'h0000);
    check("illegal_flags", 32'(flags), 32'b10001);
    accept();
    check("idle_retain_flags", 32'(flags), 32'b10001);

    // Back-pressure: result held, stray command while busy must be ignored.
    issue(4'd2, 8'hFF, 8'hFF);
    wait_valid(lat);
    check("mul_lat", 32'(lat), 32'd2);
    in_valid = 1'b1;
    opcode   = 4'd0;
    data_a   = 8'd1;
    data_b   = 8'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("mul_hold_valid", 32'(out_valid), 32'd1);
      check("mul_hold_data", 32'(data_out), 32'hFE01);
      check("mul_hold_ready", 32'(in_ready), 32'd0);
      check("mul_hold_busy", 32'(busy), 32'd1);
    end
    in_valid = 1'b0;
    accept();
    check("mul_done_valid", 32'(out_valid), 32'd0);
    check("mul_done_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("mul_no_stray", 32'(busy), 32'd0);

    // Abort a divide with reset at cycle 4.
    issue(4'd3, 8'd200, 8'd7);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_data", 32'(data_out), 32'd0);
    check("abort_flags", 32'(flags), 32'd0);
    rst = 1'b0;
    wait_valid(lat);
    check("abort_no_result", 32'(lat), 32'd99);

    issue(4'd0, 8'd1, 8'd2);
    wait_valid(lat);
    check("post_abort_lat", 32'(lat), 32'd2);
    check("post_abort_data", 32'(data_out), 32'h0003);
    check("post_abort_flags", 32'(flags), 32'b00000);
    accept();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
